// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer
//   Control stage feeding the cellular-automaton renderer. It selects the
//   active Wolfram rule byte and live-cell colour per cell-row, and requests
//   a reseed whenever the mode or the manually chosen index changes.
//   AUTO mode scrolls colour/rule bands down the screen and advances the base
//   index every FRAME_DIV frames. MANUAL mode steps the base index with the
//   next/prev buttons.
//
//   Optional feature macro: CUSTOM_RULE_EN
//     Adds a CUSTOM mode in which `rule` comes from the custom_rule switches,
//     latched once per frame. Without it, custom_rule is ignored.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-high
//   frame_start  one-cycle pulse at the first pixel of a frame
//   row_start    one-cycle pulse at the first pixel of a cell-row
//   btn_next     raw button, active-high
//   btn_prev     raw button, active-high
//   btn_mode     raw button, active-high
//   custom_rule  user rule byte (CUSTOM mode only)
//   rule         active rule byte, registered
//   color        {R[1:0],G[1:0],B[1:0]} for live cells, registered
//   rule_idx     active table index, registered
//   seed_req     one-cycle reseed request, registered
module ca_rule_sequencer #(
    parameter int BAND_ROWS = 32,
    parameter int FRAME_DIV = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       row_start,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_mode,
    input  logic [7:0] custom_rule,
    output logic [7:0] rule,
    output logic [5:0] color,
    output logic [3:0] rule_idx,
    output logic       seed_req
);

    localparam int         BAND_SHIFT = $clog2(BAND_ROWS);
    localparam logic [7:0] DIV_LAST   = 8'(FRAME_DIV - 1);
    localparam logic [9:0] ROW_MAX    = 10'd1023;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
`ifdef CUSTOM_RULE_EN
        MODE_CUSTOM = 2'd2,
`endif
        MODE_MANUAL = 2'd1
    } mode_t;

    function automatic logic [7:0] rule_lut(input logic [3:0] idx);
        case (idx)
            4'd0:  rule_lut = 8'd30;
            4'd1:  rule_lut = 8'd18;
            4'd2:  rule_lut = 8'd161;
            4'd3:  rule_lut = 8'd150;
            4'd4:  rule_lut = 8'd22;
            4'd5:  rule_lut = 8'd110;
            4'd6:  rule_lut = 8'd54;
            4'd7:  rule_lut = 8'd122;
            4'd8:  rule_lut = 8'd118;
            4'd9:  rule_lut = 8'd57;
            4'd10: rule_lut = 8'd18;
            4'd11: rule_lut = 8'd165;
            4'd12: rule_lut = 8'd90;
            4'd13: rule_lut = 8'd180;
            4'd14: rule_lut = 8'd60;
            4'd15: rule_lut = 8'd146;
        endcase
    endfunction

    // First four entries are unique; the rest cycle through a 4-colour palette.
    function automatic logic [5:0] color_lut(input logic [3:0] idx);
        if (idx[3:2] == 2'b00) begin
            case (idx[1:0])
                2'd0: color_lut = 6'b001011;
                2'd1: color_lut = 6'b101100;
                2'd2: color_lut = 6'b101001;
                2'd3: color_lut = 6'b001110;
            endcase
        end else begin
            case (idx[1:0])
                2'd0: color_lut = 6'b101010;
                2'd1: color_lut = 6'b101110;
                2'd2: color_lut = 6'b110001;
                2'd3: color_lut = 6'b100110;
            endcase
        end
    endfunction

    function automatic mode_t mode_after(input mode_t m);
        case (m)
`ifdef CUSTOM_RULE_EN
            MODE_MANUAL: mode_after = MODE_CUSTOM;
`else
            MODE_MANUAL: mode_after = MODE_AUTO;
`endif
            default:     mode_after = MODE_MANUAL;
        endcase
    endfunction

    // Debounced level: 111 sets, 000 clears, anything else holds.
    function automatic logic deb_level(input logic [2:0] sh, input logic lvl);
        if (sh == 3'b111)      deb_level = 1'b1;
        else if (sh == 3'b000) deb_level = 1'b0;
        else                   deb_level = lvl;
    endfunction

    // State registers. Button vectors are ordered {mode, prev, next}.
    mode_t      mode_q;
    logic [3:0] base_q;
    logic [7:0] div_q;
    logic [9:0] row_cnt_q;
    logic [2:0] sh_next_q, sh_prev_q, sh_mode_q;
    logic [2:0] lvl_q;

    // Next-state values.
    mode_t      mode_d;
    logic [3:0] base_d;
    logic [7:0] div_d;
    logic [9:0] row_cnt_d;
    logic [2:0] sh_next_d, sh_prev_d, sh_mode_d;
    logic [2:0] lvl_d;
    logic [2:0] press;
    logic       seed_d;
    logic [9:0] band;
    logic [3:0] idx_d;
    logic [7:0] rule_d;

`ifdef CUSTOM_RULE_EN
    logic [7:0] custom_q;
    logic [7:0] custom_d;
`else
    logic unused_custom;
    assign unused_custom = ^custom_rule;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        sh_next_d = sh_next_q;
        sh_prev_d = sh_prev_q;
        sh_mode_d = sh_mode_q;
        lvl_d     = lvl_q;
        mode_d    = mode_q;
        base_d    = base_q;
        div_d     = div_q;
        seed_d    = 1'b0;

        // Buttons are sampled only at frame_start, so a press event is acted
        // on in the very update that completes the 111 pattern.
        if (frame_start) begin
            sh_next_d = {sh_next_q[1:0], btn_next};
            sh_prev_d = {sh_prev_q[1:0], btn_prev};
            sh_mode_d = {sh_mode_q[1:0], btn_mode};
            lvl_d     = {deb_level(sh_mode_d, lvl_q[2]),
                         deb_level(sh_prev_d, lvl_q[1]),
                         deb_level(sh_next_d, lvl_q[0])};
        end
        press = lvl_d & ~lvl_q;

        if (frame_start) begin
            if (press[2]) begin
                // Mode change keeps the base index and restarts the divider.
                mode_d = mode_after(mode_q);
                div_d  = 8'd0;
                seed_d = 1'b1;
            end else if (mode_q == MODE_AUTO) begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    base_d = base_q + 4'd1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end else if (mode_q == MODE_MANUAL && (press[0] ^ press[1])) begin
                base_d = press[0] ? base_q + 4'd1 : base_q - 4'd1;
                seed_d = 1'b1;
            end
        end
        // Guarantees the request can never stretch across two cycles.
        seed_d = seed_d & ~seed_req;

        if (frame_start)
            row_cnt_d = 10'd0;
        else if (row_start && row_cnt_q != ROW_MAX)
            row_cnt_d = row_cnt_q + 10'd1;
        else
            row_cnt_d = row_cnt_q;

        band  = row_cnt_d >> BAND_SHIFT;
        idx_d = (mode_d == MODE_AUTO) ? base_d + band[3:0] : base_d;

`ifdef CUSTOM_RULE_EN
        custom_d = frame_start ? custom_rule : custom_q;
        rule_d   = (mode_d == MODE_CUSTOM) ? custom_d : rule_lut(idx_d);
`else
        rule_d   = rule_lut(idx_d);
`endif
    end

    // Outputs are registered from next-state values, so they change exactly one
    // cycle after the frame_start/row_start that caused it and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_AUTO;
            base_q    <= 4'd0;
            div_q     <= 8'd0;
            row_cnt_q <= 10'd0;
            sh_next_q <= 3'd0;
            sh_prev_q <= 3'd0;
            sh_mode_q <= 3'd0;
            lvl_q     <= 3'd0;
            rule      <= 8'd30;
            color     <= 6'b001011;
            rule_idx  <= 4'd0;
            seed_req  <= 1'b0;
`ifdef CUSTOM_RULE_EN
            custom_q  <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            mode_q    <= mode_d;
            base_q    <= base_d;
            div_q     <= div_d;
            row_cnt_q <= row_cnt_d;
            sh_next_q <= sh_next_d;
            sh_prev_q <= sh_prev_d;
            sh_mode_q <= sh_mode_d;
            lvl_q     <= lvl_d;
            rule      <= rule_d;
            color     <= color_lut(idx_d);
            rule_idx  <= idx_d;
            seed_req  <= seed_d;
`ifdef CUSTOM_RULE_EN
            custom_q  <= custom_d;
`endif
        end
    end

endmodule
